// File: rtl/encoder_proj.sv
// encoder_proj: FIFO-buffered Hamming(7,4) encoder with valid/ready handshakes and optional single-bit error injection.
module encoder_proj #(
  parameter int DEPTH = 4,
  parameter int LW = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [3:0]    in_data,
  output logic          in_ready,
  input  logic [2:0]    err_pos,
  output logic [6:0]    io_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [LW-1:0] level,
  output logic [7:0]    cw_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [3:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, load;
  logic [3:0] d;
  logic [6:0] code, mask;
  assign in_ready = level != LW'(DEPTH);
  assign push = in_valid & in_ready;
  assign load = (level != '0) & (~out_valid | out_ready);
  assign d = mem[rd_ptr];
  assign code = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  assign mask = (err_pos == 3'd0) ? 7'd0 : 7'd1 << (err_pos - 3'd1);
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= in_data;
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      io_out <= '0;
      out_valid <= 1'b0;
      cw_count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (load) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      level <= level + LW'(push) - LW'(load);
      cw_count <= cw_count + 8'(out_valid & out_ready);
      if (load) begin
        io_out <= code ^ mask;
        out_valid <= 1'b1;
      end else if (out_valid & out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_encoder_proj.sv
// tb_encoder_proj: directed scoreboard bench for encoder_proj.
module tb_encoder_proj;
  logic clock = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [3:0] in_data = '0;
  logic [2:0] err_pos = '0;
  logic in_ready, out_valid;
  logic [6:0] io_out;
  logic [2:0] level;
  logic [7:0] cw_count;
  int n_chk = 0, n_fail = 0;
  typedef struct packed { logic [3:0] nib; logic [2:0] err; } item_t;
  item_t q[$];

  encoder_proj dut (.clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .err_pos(err_pos), .io_out(io_out), .out_valid(out_valid),
    .out_ready(out_ready), .level(level), .cw_count(cw_count));

  always #5 clock = ~clock;

  function automatic logic [6:0] enc(input logic [3:0] v, input logic [2:0] e);
    logic [6:0] c;
    c = '0;
    c[2] = v[0]; c[4] = v[1]; c[5] = v[2]; c[6] = v[3];
    for (int i = 0; i < 3; i++)
      for (int k = 1; k <= 7; k++)
        if (((k & (1 << i)) != 0) && k != (1 << i)) c[(1 << i) - 1] ^= c[k - 1];
    if (e != 0) c[e - 1] = ~c[e - 1];
    return c;
  endfunction

  function automatic logic [2:0] syn(input logic [6:0] c);
    logic [2:0] s;
    s = '0;
    for (int k = 1; k <= 7; k++) if (c[k - 1]) s ^= 3'(k);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    item_t it;
    @(negedge clock);
    if (out_valid && out_ready) begin
      n_chk++;
      assert (q.size() > 0) else begin
        n_fail++;
        $error("FAIL spurious_cw observed=%0h expected=none", io_out);
      end
      if (q.size() > 0) begin
        it = q.pop_front();
        chk("codeword", 32'(io_out), 32'(enc(it.nib, it.err)));
        if (it.err == 0) begin
          chk("syndrome", 32'(syn(io_out)), 32'd0);
          chk("decoded", 32'({io_out[6], io_out[5], io_out[4], io_out[2]}), 32'(it.nib));
        end
      end
    end
    if (in_valid && in_ready) q.push_back('{in_data, err_pos});
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    err_pos = '0;
    q.delete();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int b;
    b = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while ((q.size() > 0 || out_valid) && b < 50) begin
      cycle();
      b++;
    end
    chk("drain_timeout", 32'(b < 50), 32'd1);
  endtask

  initial begin
    #2;
    chk("rst_io_out", 32'(io_out), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_cw_count", 32'(cw_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clock);
    #1;
    // latency: accepted at edge 1, visible after edge 2, handed off at edge 3
    in_valid = 1'b1; in_data = 4'b1011;
    cycle();
    in_valid = 1'b0;
    chk("t1_not_yet", 32'(out_valid), 32'd0);
    cycle();
    chk("t1_io_out", 32'(io_out), 32'h55);
    chk("t1_valid", 32'(out_valid), 32'd1);
    cycle();
    chk("t1_drained", 32'(out_valid), 32'd0);
    chk("t1_cw_count", 32'(cw_count), 32'd1);

    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = (i == 0) ? 4'h0 : (i == 1) ? 4'hF : 4'h1;
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    cycle();
    chk("t2_cw_count", 32'(cw_count), 32'd3);
    chk("t2_sb_empty", 32'(q.size()), 32'd0);
    chk("t2_idle", 32'(out_valid), 32'd0);

    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 4'(i + 6);
      cycle();
    end
    chk("t3_level", 32'(level), 32'd4);
    chk("t3_in_ready", 32'(in_ready), 32'd0);
    chk("t3_hold", 32'(io_out), 32'(enc(4'd6, 3'd0)));
    in_data = 4'hA;
    cycle();
    chk("t3_refused_level", 32'(level), 32'd4);
    chk("t3_sb_size", 32'(q.size()), 32'd5);
    drain();
    chk("t3_level_end", 32'(level), 32'd0);
    chk("t3_cw_count", 32'(cw_count), 32'd8);

    err_pos = 3'd3; in_valid = 1'b1; in_data = 4'hF;
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("t4_err_cw", 32'(io_out), 32'h7B);
    err_pos = 3'd0; in_valid = 1'b1;
    cycle();
    drain();
    chk("t4_clean_cw", 32'(io_out), 32'h7F);

    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 4'(i + 1);
      cycle();
    end
    in_valid = 1'b0;
    chk("t5_level", 32'(level), 32'd3);
    chk("t5_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_io_out", 32'(io_out), 32'd0);
    chk("t5_async_valid", 32'(out_valid), 32'd0);
    chk("t5_async_level", 32'(level), 32'd0);
    chk("t5_async_cw", 32'(cw_count), 32'd0);
    chk("t5_async_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t5_no_stale", 32'(out_valid), 32'd0);
    end

    do_reset();
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; in_data = 4'($urandom_range(0, 15));
      cycle();
    end
    drain();
    chk("t6_cw_wrap", 32'(cw_count), 32'd0);
    chk("t6_level", 32'(level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
